// File: rtl/cpu_pkg.sv
// Shared CPU types: M_MUX select encoding, the M_MUX controller states and
// requester indices, plus the modulo-3 successor used by the round-robin logic.
package cpu_pkg;

   typedef enum logic [1:0] {
      SEL_INSTR = 2'd0,
      SEL_MMR   = 2'd1,
      SEL_STACK = 2'd2,
      SEL_ZERO  = 2'd3
   } mux_sel_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      LOAD = 2'd2
   } m_mux_ctrl_state_e;

   localparam logic [1:0] REQ_INSTR = 2'd0;
   localparam logic [1:0] REQ_MMR   = 2'd1;
   localparam logic [1:0] REQ_STACK = 2'd2;

   // Successor in the 0 -> 1 -> 2 -> 0 ring; the unused code 3 folds to 0.
   function automatic logic [1:0] rr_next(input logic [1:0] k);
      return (k >= 2'd2) ? 2'd0 : k + 2'd1;
   endfunction

endpackage

// File: rtl/m_mux_ctrl_arb.sv
// Three-way round-robin arbiter: searches ptr, ptr+1, ptr+2 (mod 3) and
// returns the first requester found as a one-hot grant plus its index.
module rr_arbiter3
   import cpu_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [2:0] gnt,
   output logic [1:0] idx
);

   logic [1:0] cand;
   logic       found;

   always_comb begin
      gnt   = 3'b000;
      idx   = REQ_INSTR;
      found = 1'b0;
      cand  = (ptr == 2'd3) ? REQ_INSTR : ptr;
      for (int i = 0; i < 3; i++) begin
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
         cand = rr_next(cand);
      end
   end

endmodule

// File: rtl/m_mux_ctrl.sv
// M_MUX sequencing controller: round-robin owner selection, per-source settle
// time on the select, then a one-cycle MDR load strobe and completion pulse.
module m_mux_ctrl
   import cpu_pkg::*;
#(
   parameter int WAIT_INSTR = 1,
   parameter int WAIT_MMR   = 2,
   parameter int WAIT_STACK = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
   output logic [2:0] grant,
   output logic [2:0] done,
   output logic [1:0] sel,
   output logic       mdr_load,
   output logic       busy,
   output logic [1:0] dbg_state
);

   if (WAIT_INSTR < 0 || WAIT_INSTR > 15 || WAIT_MMR < 0 || WAIT_MMR > 15 ||
       WAIT_STACK < 0 || WAIT_STACK > 15) begin : g_param_err
      $error("m_mux_ctrl: WAIT_* parameters must be within 0..15");
   end

   localparam logic [3:0] W_INSTR = 4'(WAIT_INSTR);
   localparam logic [3:0] W_MMR   = 4'(WAIT_MMR);
   localparam logic [3:0] W_STACK = 4'(WAIT_STACK);

   function automatic logic [3:0] wait_of(input logic [1:0] k);
      case (k)
         REQ_INSTR: return W_INSTR;
         REQ_MMR:   return W_MMR;
         REQ_STACK: return W_STACK;
         default:   return 4'd0;
      endcase
   endfunction

   m_mux_ctrl_state_e state, state_n;
   logic [3:0]        cnt, cnt_n;
   logic [2:0]        grant_n;
   logic [1:0]        sel_n;
   logic [1:0]        owner, owner_n;
   logic [1:0]        rr_ptr, rr_ptr_n;
   logic [2:0]        arb_gnt;
   logic [1:0]        arb_idx;

   rr_arbiter3 u_arb (
      .req (req),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         grant  <= 3'b000;
         sel    <= SEL_ZERO;
         owner  <= REQ_INSTR;
         rr_ptr <= REQ_INSTR;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         grant  <= grant_n;
         sel    <= sel_n;
         owner  <= owner_n;
         rr_ptr <= rr_ptr_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      grant_n  = grant;
      sel_n    = sel;
      owner_n  = owner;
      rr_ptr_n = rr_ptr;
      case (state)
         IDLE: begin
            if (|req) begin
               grant_n = arb_gnt;
               sel_n   = arb_idx;
               owner_n = arb_idx;
               cnt_n   = wait_of(arb_idx);
               state_n = (wait_of(arb_idx) == 4'd0) ? LOAD : WAIT;
            end
         end
         WAIT: begin
            // Count of 1 is the last settle cycle; 0 cannot occur here but is
            // treated the same so the FSM can never stall.
            if (cnt <= 4'd1) state_n = LOAD;
            if (cnt != 4'd0) cnt_n = cnt - 4'd1;
         end
         LOAD: begin
            state_n  = IDLE;
            cnt_n    = 4'd0;
            grant_n  = 3'b000;
            sel_n    = SEL_ZERO;
            rr_ptr_n = rr_next(owner);
         end
         default: begin
            state_n = IDLE;
            grant_n = 3'b000;
            sel_n   = SEL_ZERO;
         end
      endcase
   end

   assign mdr_load  = (state == LOAD);
   assign done      = mdr_load ? grant : 3'b000;
   assign busy      = (state != IDLE);
   assign dbg_state = state;

   a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
   a_done_load     : assert property (@(posedge clk) disable iff (rst) (|done) |-> mdr_load);
   a_sel_zero      : assert property (@(posedge clk) disable iff (rst)
                                      ((sel == SEL_ZERO) == (grant == 3'b000)));

endmodule

// File: tb/tb_m_mux_ctrl.sv
// Directed bench for m_mux_ctrl: cycle table for reset/single transfers,
// then hand-written fairness, mid-WAIT drop and mid-transfer reset sequences.
module tb_m_mux_ctrl;

   logic       clk;
   logic       rst, rst3;
   logic [2:0] req, req3;
   logic [2:0] grant, done, grant3, done3;
   logic [1:0] sel, sel3, dbg_state, dbg_state3;
   logic       mdr_load, busy, mdr_load3, busy3;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [1:0] exp_q[$];

   // Default-parameter controller
   m_mux_ctrl u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .grant     (grant),
      .done      (done),
      .sel       (sel),
      .mdr_load  (mdr_load),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // Longer instruction settle time for the mid-WAIT drop sequence
   m_mux_ctrl #(.WAIT_INSTR(3)) u_dut3 (
      .clk       (clk),
      .rst       (rst3),
      .req       (req3),
      .grant     (grant3),
      .done      (done3),
      .sel       (sel3),
      .mdr_load  (mdr_load3),
      .busy      (busy3),
      .dbg_state (dbg_state3)
   );

   // Clock and cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic       rst;
      logic [2:0] req;
      logic [2:0] grant;
      logic [1:0] sel;
      logic [2:0] done;
      logic       mdr;
      logic       busy;
   } vec_t;

   vec_t tbl[18];

   function automatic vec_t mk(input logic r, input logic [2:0] q, input logic [2:0] g,
                               input logic [1:0] s, input logic [2:0] d,
                               input logic m, input logic b);
      vec_t v;
      v.rst = r; v.req = q; v.grant = g; v.sel = s; v.done = d; v.mdr = m; v.busy = b;
      return v;
   endfunction

   function automatic int tb_wait(input logic [1:0] k);
      case (k)
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string name);
      chk({name, " grant"}, 32'(grant), 32'(3'b000));
      chk({name, " sel"}, 32'(sel), 32'(2'd3));
      chk({name, " done"}, 32'(done), 32'(3'b000));
      chk({name, " mdr_load"}, 32'(mdr_load), 32'(1'b0));
      chk({name, " busy"}, 32'(busy), 32'(1'b0));
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      req = 3'b000;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int t0, last, ndone, timeout;
      int per_req[3];
      logic [1:0] k, e;

      rst  = 1'b1;
      req  = 3'b111;
      rst3 = 1'b1;
      req3 = 3'b000;
      tick();

      // Cycle-by-cycle table: reset, MMR (W=2), stack (W=0), instr, MMR dropping req
      tbl[0]  = mk(1, 3'b111, 3'b000, 2'd3, 3'b000, 0, 0);
      tbl[1]  = mk(1, 3'b111, 3'b000, 2'd3, 3'b000, 0, 0);
      tbl[2]  = mk(0, 3'b010, 3'b000, 2'd3, 3'b000, 0, 0);
      tbl[3]  = mk(0, 3'b010, 3'b010, 2'd1, 3'b000, 0, 1);
      tbl[4]  = mk(0, 3'b010, 3'b010, 2'd1, 3'b000, 0, 1);
      tbl[5]  = mk(0, 3'b010, 3'b010, 2'd1, 3'b010, 1, 1);
      tbl[6]  = mk(0, 3'b000, 3'b000, 2'd3, 3'b000, 0, 0);
      tbl[7]  = mk(0, 3'b100, 3'b000, 2'd3, 3'b000, 0, 0);
      tbl[8]  = mk(0, 3'b100, 3'b100, 2'd2, 3'b100, 1, 1);
      tbl[9]  = mk(0, 3'b000, 3'b000, 2'd3, 3'b000, 0, 0);
      tbl[10] = mk(0, 3'b011, 3'b000, 2'd3, 3'b000, 0, 0);
      tbl[11] = mk(0, 3'b011, 3'b001, 2'd0, 3'b000, 0, 1);
      tbl[12] = mk(0, 3'b011, 3'b001, 2'd0, 3'b001, 1, 1);
      tbl[13] = mk(0, 3'b010, 3'b000, 2'd3, 3'b000, 0, 0);
      tbl[14] = mk(0, 3'b000, 3'b010, 2'd1, 3'b000, 0, 1);
      tbl[15] = mk(0, 3'b000, 3'b010, 2'd1, 3'b000, 0, 1);
      tbl[16] = mk(0, 3'b000, 3'b010, 2'd1, 3'b010, 1, 1);
      tbl[17] = mk(0, 3'b000, 3'b000, 2'd3, 3'b000, 0, 0);

      for (int i = 0; i < 18; i++) begin
         rst = tbl[i].rst;
         req = tbl[i].req;
         @(negedge clk);
         chk($sformatf("row%0d grant", i), 32'(grant), 32'(tbl[i].grant));
         chk($sformatf("row%0d sel", i), 32'(sel), 32'(tbl[i].sel));
         chk($sformatf("row%0d done", i), 32'(done), 32'(tbl[i].done));
         chk($sformatf("row%0d mdr_load", i), 32'(mdr_load), 32'(tbl[i].mdr));
         chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].busy));
         tick();
      end

      // Fairness: all three requesting continuously for nine transfers
      reset_dut();
      req = 3'b111;
      t0 = cyc;
      last = 0;
      ndone = 0;
      per_req = '{0, 0, 0};
      for (int n = 0; n < 9; n++) exp_q.push_back(2'(n % 3));
      timeout = 0;
      while (ndone < 9 && timeout < 200) begin
         @(negedge clk);
         if (done != 3'b000) begin
            k = (done == 3'b001) ? 2'd0 : (done == 3'b010) ? 2'd1 : 2'd2;
            e = exp_q.pop_front();
            chk($sformatf("fair done%0d onehot", ndone), 32'($onehot(done)), 32'd1);
            chk($sformatf("fair done%0d owner", ndone), 32'(k), 32'(e));
            if (ndone == 0)
               chk("fair first latency", 32'(cyc - t0), 32'(2));
            else
               chk($sformatf("fair gap%0d", ndone), 32'(cyc - last), 32'(tb_wait(e) + 2));
            if (k != 2'd3) per_req[k]++;
            last = cyc;
            ndone++;
         end
         timeout++;
         tick();
      end
      chk("fair total dones", 32'(ndone), 32'd9);
      for (int r = 0; r < 3; r++)
         chk($sformatf("fair count req%0d", r), 32'(per_req[r]), 32'd3);
      req = 3'b000;
      tick();
      tick();

      // Instr drops req mid-WAIT (WAIT_INSTR=3): transfer still completes
      rst3 = 1'b1;
      tick();
      tick();
      rst3 = 1'b0;
      req3 = 3'b011;
      @(negedge clk);
      chk("drop t idle grant", 32'(grant3), 32'(3'b000));
      tick();
      req3 = 3'b010;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk($sformatf("drop t+%0d grant", c), 32'(grant3), 32'(3'b001));
         chk($sformatf("drop t+%0d done", c), 32'(done3), 32'(3'b000));
         tick();
      end
      @(negedge clk);
      chk("drop t+4 done", 32'(done3), 32'(3'b001));
      chk("drop t+4 mdr_load", 32'(mdr_load3), 32'(1'b1));
      tick();
      @(negedge clk);
      chk("drop t+5 idle busy", 32'(busy3), 32'(1'b0));
      tick();
      @(negedge clk);
      chk("drop t+6 grant mmr", 32'(grant3), 32'(3'b010));
      chk("drop t+6 sel mmr", 32'(sel3), 32'(2'd1));
      req3 = 3'b000;

      // Reset mid-transfer: instr completes (ptr->mmr), MMR is cut off by reset
      reset_dut();
      req = 3'b001;
      tick();
      tick();
      @(negedge clk);
      chk("rst seq instr done", 32'(done), 32'(3'b001));
      req = 3'b010;
      tick();
      tick();
      @(negedge clk);
      chk("rst seq mmr grant", 32'(grant), 32'(3'b010));
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("rst seq wait done", 32'(done), 32'(3'b000));
      chk("rst seq wait busy", 32'(busy), 32'(1'b1));
      tick();
      rst = 1'b0;
      req = 3'b011;
      @(negedge clk);
      chk_idle("rst seq after reset");
      tick();
      @(negedge clk);
      chk("rst seq ptr cleared grant", 32'(grant), 32'(3'b001));
      chk("rst seq ptr cleared sel", 32'(sel), 32'(2'd0));
      chk("rst seq no mmr done", 32'(done), 32'(3'b000));
      req = 3'b000;
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
